count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_sequencer.sv | 146 ++++++++++++++
 tb/tb_count_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// count_sequencer: run/pause/load 8-bit counter with prescaled tick and a sequential BCD image.
// Optional feature macro COUNT_SEQ_DOWN_EN: when defined, dir selects up (1) or down (0) counting.
module count_sequencer #(
    parameter int PRESCALE = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dir,
    output logic [7:0] count,
    output logic       tick,
    output logic [1:0] state,
    output logic [3:0] ONES,
    output logic [3:0] TENS,
    output logic [1:0] HUNDREDS,
    output logic       bcd_valid
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;

    state_t        state_q, state_d;
    logic [2:0]    in_q, in_d, arm_q, arm_d, req;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    count_q, count_d, step_val;
    logic          busy_q, busy_d, pend_q, pend_d, valid_q, valid_d, chg;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [9:0]    work_q, work_d, bcd_q, bcd_d;
    logic [8:0]    adj;

`ifdef COUNT_SEQ_DOWN_EN
    assign step_val = dir ? 8'd1 : 8'hFF;
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign step_val   = 8'd1;
`endif

    // Edge detect {load, stop, start}; an input must be seen low after reset before it can request
    always_comb begin
        in_d  = {load, stop, start};
        arm_d = arm_q | ~in_d;
        req   = in_d & ~in_q & arm_q;
    end

    // Run control: load wins over stop/start and freezes the FSM; prescaler and count follow
    always_comb begin
        tick    = (state_q == RUN) && (pre_q == PRE_LAST) && !req[2];
        state_d = state_q;
        pre_d   = pre_q;
        count_d = count_q;
        if (req[2]) begin
            pre_d   = '0;
            count_d = load_val;
        end else begin
            if (tick)
                count_d = count_q + step_val;
            if (state_q == RUN)
                pre_d = tick ? '0 : pre_q + 1'b1;
            else if (state_q == IDLE)
                pre_d = '0;
            if (req[1])
                state_d = (state_q == RUN) ? PAUSE : (state_q == PAUSE) ? IDLE : state_q;
            else if (req[0] && state_q != RUN)
                state_d = RUN;
        end
    end

    // Double-dabble: 8 add-3/shift steps then a write step; a change mid-run forces a restart
    always_comb begin
        chg     = count_d != count_q;
        adj     = {work_q[8],
                   (work_q[7:4] >= 4'd5) ? work_q[7:4] + 4'd3 : work_q[7:4],
                   (work_q[3:0] >= 4'd5) ? work_q[3:0] + 4'd3 : work_q[3:0]};
        busy_d  = busy_q;
        pend_d  = pend_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        valid_d = valid_q && !chg;
        if (busy_q && bit_q == 4'd8) begin
            if (pend_q || chg) begin
                pend_d = 1'b0;
                bit_d  = '0;
                sh_d   = count_d;
                work_d = '0;
            end else begin
                busy_d  = 1'b0;
                bcd_d   = work_q;
                valid_d = 1'b1;
            end
        end else if (busy_q) begin
            pend_d         = pend_q || chg;
            bit_d          = bit_q + 4'd1;
            {work_d, sh_d} = {adj, sh_q, 1'b0};
        end else if (chg) begin
            busy_d = 1'b1;
            bit_d  = '0;
            sh_d   = count_d;
            work_d = '0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            in_q    <= '0;
            arm_q   <= '0;
            pre_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
            bit_q   <= '0;
            sh_q    <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b1;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            arm_q   <= arm_d;
            pre_q   <= pre_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign count                    = count_q;
    assign state                    = state_q;
    assign {HUNDREDS, TENS, ONES}   = bcd_q;
    assign bcd_valid                = valid_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed scenarios plus random stimulus against a cycle-level behavioural model.
module tb_count_sequencer;
    logic       CLOCK_50 = 1'b0, RESET_N = 1'b0;
    logic       start = 1'b0, stop = 1'b0, load = 1'b0, dir = 1'b1;
    logic [7:0] load_val = 8'd0;
    logic [7:0] count;
    logic       tick, bcd_valid;
    logic [1:0] state, HUNDREDS;
    logic [3:0] ONES, TENS;

    count_sequencer #(.PRESCALE(10)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .dir(dir), .count(count), .tick(tick), .state(state),
        .ONES(ONES), .TENS(TENS), .HUNDREDS(HUNDREDS), .bcd_valid(bcd_valid)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0, bad = 0, ticks_seen = 0;

    // reference model: state 0 idle / 1 run / 2 pause, plain integer arithmetic
    int m_state, m_pre, m_cnt, m_val, m_age, m_hund, m_tens, m_ones;
    bit m_valid, m_busy, m_pend;
    bit m_prev [3];
    bit m_seen_low [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_in(input int i);
        return (i == 0) ? start : (i == 1) ? stop : load;
    endfunction

    function automatic bit m_req(input int i);
        return m_in(i) && !m_prev[i] && m_seen_low[i];
    endfunction

    function automatic bit m_tick();
        return m_state == 1 && m_pre == 9 && !m_req(2);
    endfunction

    task automatic m_reset();
        m_state = 0; m_pre = 0; m_cnt = 0; m_val = 0; m_age = 0;
        m_hund = 0; m_tens = 0; m_ones = 0;
        m_valid = 1; m_busy = 0; m_pend = 0;
        for (int i = 0; i < 3; i++) begin
            m_prev[i] = 0;
            m_seen_low[i] = 0;
        end
    endtask

    task automatic m_edge();
        bit ss, ps, ls, tk;
        int nc, inc;
`ifdef COUNT_SEQ_DOWN_EN
        inc = dir ? 1 : 255;
`else
        inc = 1;
`endif
        ss = m_req(0); ps = m_req(1); ls = m_req(2); tk = m_tick();
        nc = ls ? int'(load_val) : tk ? (m_cnt + inc) % 256 : m_cnt;
        if (ls) m_pre = 0;
        else if (m_state == 1) m_pre = tk ? 0 : m_pre + 1;
        else if (m_state == 0) m_pre = 0;
        if (!ls) begin
            if (ps) m_state = (m_state == 1) ? 2 : (m_state == 2) ? 0 : m_state;
            else if (ss) m_state = 1;
        end
        if (nc != m_cnt) m_valid = 0;
        if (m_busy) begin
            m_age++;
            if (m_age == 9) begin
                if (m_pend || nc != m_cnt) begin
                    m_age = 0; m_pend = 0; m_val = nc;
                end else begin
                    m_busy = 0; m_valid = 1;
                    m_hund = m_val / 100; m_tens = (m_val / 10) % 10; m_ones = m_val % 10;
                end
            end else if (nc != m_cnt) m_pend = 1;
        end else if (nc != m_cnt) begin
            m_busy = 1; m_age = 0; m_val = nc;
        end
        m_cnt = nc;
        for (int i = 0; i < 3; i++) begin
            if (!m_in(i)) m_seen_low[i] = 1;
            m_prev[i] = m_in(i);
        end
    endtask

    task automatic step(input logic s = 0, input logic p = 0, input logic l = 0,
                        input logic [7:0] lv = 0, input logic d = 1);
        logic [9:0] mb;
        start = s; stop = p; load = l; load_val = lv; dir = d;
        #1;
        mb = {m_hund[1:0], m_tens[3:0], m_ones[3:0]};
        chk("count", count, m_cnt);
        chk("state", state, m_state);
        chk("tick", tick, m_tick());
        chk("bcd_valid", bcd_valid, m_valid);
        chk("bcd", {HUNDREDS, TENS, ONES}, mb);
        ticks_seen += int'(tick);
        @(posedge CLOCK_50);
        m_edge();
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset(input logic s, input logic p, input logic l);
        start = s; stop = p; load = l;
        RESET_N = 1'b0;
        m_reset();
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
    endtask

    initial begin
        bit any_valid, saw_123;
        m_reset();
        // reset release
        do_reset(0, 0, 0);
        chk("rst_count", count, 0);
        chk("rst_state", state, 0);
        chk("rst_valid", bcd_valid, 1);
        chk("rst_bcd", {HUNDREDS, TENS, ONES}, 0);
        step();
        // start then 30 cycles: ticks at 10, 20, 30
        ticks_seen = 0;
        step(1);
        repeat (30) step();
        chk("run_ticks", ticks_seen, 3);
        chk("run_count", count, 3);
        repeat (9) step();
        chk("run_bcd_valid", bcd_valid, 1);
        chk("run_bcd", {HUNDREDS, TENS, ONES}, 10'h003);
        // back to idle, load 255, start, wrap, pause and resume
        step(0, 1); step(); step(0, 1); step();
        chk("idle_state", state, 0);
        step(0, 0, 1, 8'd255); step();
        step(1);
        repeat (10) step();
        chk("wrap_count", count, 0);
        repeat (4) step();
        step(0, 1);
        chk("pause_state", state, 2);
        repeat (5) step();
        step(1);
        repeat (4) step();
        chk("resume_tick", tick, 1);
        // pause, let conversion settle, then back-to-back loads
        step(0, 1); step();
        repeat (12) step();
        step(0, 0, 1, 8'd123);
        repeat (3) step();
        step(0, 0, 1, 8'd200);
        any_valid = 0; saw_123 = 0;
        repeat (13) begin
            step();
            any_valid |= bcd_valid;
            saw_123 |= ({HUNDREDS, TENS, ONES} == 10'h123);
        end
        chk("reload_no_valid", any_valid, 0);
        chk("reload_no_123", saw_123, 0);
        step();
        chk("reload_valid", bcd_valid, 1);
        chk("reload_bcd", {HUNDREDS, TENS, ONES}, 10'h200);
        // load and stop together while running
        step(1); step();
        step(0, 1, 1, 8'd77);
        chk("ldstop_count", count, 77);
        chk("ldstop_state", state, 1);
        step();
`ifdef COUNT_SEQ_DOWN_EN
        step(0, 0, 1, 8'd0, 0);
        repeat (10) step(0, 0, 0, 8'd0, 0);
        chk("down_count", count, 255);
        repeat (9) step(0, 0, 0, 8'd0, 0);
        chk("down_bcd", {HUNDREDS, TENS, ONES}, 10'h255);
        chk("down_valid", bcd_valid, 1);
`endif
        // inputs high at reset release are not requests
        do_reset(1, 0, 0);
        repeat (3) step(1);
        chk("held_start_idle", state, 0);
        step(0); step(1);
        chk("rearm_start_run", state, 1);
        // asynchronous reset in the middle of a conversion
        step(0, 0, 1, 8'd45);
        repeat (3) step();
        #3 RESET_N = 1'b0;
        m_reset();
        #1;
        chk("arst_count", count, 0);
        chk("arst_state", state, 0);
        chk("arst_tick", tick, 0);
        chk("arst_valid", bcd_valid, 1);
        chk("arst_bcd", {HUNDREDS, TENS, ONES}, 0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        // random traffic
        repeat (1500)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 8'($urandom), 1'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
